// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts bubbles on load-use, squashes on flush, freezes on hold.
module id_ex_hazard_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [REG_W-1:0]  IF_ID_rs1,
    input  logic [REG_W-1:0]  IF_ID_rs2,
    input  logic [REG_W-1:0]  IF_ID_rd,
    input  logic              IF_ID_use_rs1,
    input  logic              IF_ID_use_rs2,
    input  logic [8:0]        ID_ctrl,
    input  logic [DATA_W-1:0] ID_rdata1,
    input  logic [DATA_W-1:0] ID_rdata2,
    input  logic [DATA_W-1:0] ID_imm,
    input  logic [DATA_W-1:0] ID_pc,
    input  logic [3:0]        ID_funct,
    output logic [8:0]        ID_EX_ctrl,
    output logic [DATA_W-1:0] ID_EX_rdata1,
    output logic [DATA_W-1:0] ID_EX_rdata2,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic [DATA_W-1:0] ID_EX_pc,
    output logic [3:0]        ID_EX_funct,
    output logic [REG_W-1:0]  ID_EX_rs1,
    output logic [REG_W-1:0]  ID_EX_rs2,
    output logic [REG_W-1:0]  ID_EX_rd,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  bubble_count
);

    // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg,
    //         Branch, ALUSrc, ALUOp[1:0], Funct_valid}
    localparam int MEMREAD_BIT = 7;

    typedef struct packed {
        logic [8:0]        ctrl;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [3:0]        funct;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
    } id_ex_t;

    id_ex_t           stage_q;
    id_ex_t           stage_d;
    id_ex_t           id_in;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    // Gather the ID-stage fields into one bundle.
    always_comb begin
        id_in        = '0;
        id_in.ctrl   = ID_ctrl;
        id_in.rdata1 = ID_rdata1;
        id_in.rdata2 = ID_rdata2;
        id_in.imm    = ID_imm;
        id_in.pc     = ID_pc;
        id_in.funct  = ID_funct;
        id_in.rs1    = IF_ID_rs1;
        id_in.rs2    = IF_ID_rs2;
        id_in.rd     = IF_ID_rd;
    end

    // A load in EX whose non-x0 rd is read by the ID instruction.
    always_comb begin
        rs1_hit  = IF_ID_use_rs1 && (stage_q.rd == IF_ID_rs1);
        rs2_hit  = IF_ID_use_rs2 && (stage_q.rd == IF_ID_rs2);
        load_use = stage_q.ctrl[MEMREAD_BIT]
                 && (stage_q.rd != '0)
                 && (rs1_hit || rs2_hit);
    end

    // Front end stalls on load-use or hold; flush does not gate it.
    always_comb begin
        PC_Write    = !(load_use || hold);
        IF_ID_Write = !(load_use || hold);
    end

    // Next state: flush beats hold beats load-use beats capture.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (flush) begin
            stage_d = '0;
        end else if (!hold) begin
            if (load_use) begin
                stage_d = '0;
                if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                stage_d = id_in;
            end
        end
    end

    // Pipeline register and saturating bubble counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ID_EX_ctrl   = stage_q.ctrl;
    assign ID_EX_rdata1 = stage_q.rdata1;
    assign ID_EX_rdata2 = stage_q.rdata2;
    assign ID_EX_imm    = stage_q.imm;
    assign ID_EX_pc     = stage_q.pc;
    assign ID_EX_funct  = stage_q.funct;
    assign ID_EX_rs1    = stage_q.rs1;
    assign ID_EX_rs2    = stage_q.rs2;
    assign ID_EX_rd     = stage_q.rd;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: table vectors, hand sequences,
// random stimulus against a behavioural model.
module tb_id_ex_hazard_reg;

    localparam int DW  = 64;
    localparam int RW  = 5;
    localparam int CW  = 16;
    localparam int CWS = 2;

    localparam logic [8:0] C_ADD  = 9'h105;
    localparam logic [8:0] C_LD   = 9'h1A8;
    localparam logic [8:0] C_ADDI = 9'h10D;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hold;
    logic          flush;
    logic [RW-1:0] IF_ID_rs1;
    logic [RW-1:0] IF_ID_rs2;
    logic [RW-1:0] IF_ID_rd;
    logic          IF_ID_use_rs1;
    logic          IF_ID_use_rs2;
    logic [8:0]    ID_ctrl;
    logic [DW-1:0] ID_rdata1;
    logic [DW-1:0] ID_rdata2;
    logic [DW-1:0] ID_imm;
    logic [DW-1:0] ID_pc;
    logic [3:0]    ID_funct;

    logic [8:0]    ID_EX_ctrl, s_ctrl;
    logic [DW-1:0] ID_EX_rdata1, s_rdata1;
    logic [DW-1:0] ID_EX_rdata2, s_rdata2;
    logic [DW-1:0] ID_EX_imm, s_imm;
    logic [DW-1:0] ID_EX_pc, s_pc;
    logic [3:0]    ID_EX_funct, s_funct;
    logic [RW-1:0] ID_EX_rs1, s_rs1;
    logic [RW-1:0] ID_EX_rs2, s_rs2;
    logic [RW-1:0] ID_EX_rd, s_rd;
    logic          PC_Write, s_pcw;
    logic          IF_ID_Write, s_ifw;
    logic [CW-1:0] bubble_count;
    logic [CWS-1:0] s_bubble_count;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_rd(IF_ID_rd),
        .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_ctrl(ID_ctrl), .ID_rdata1(ID_rdata1),
        .ID_rdata2(ID_rdata2), .ID_imm(ID_imm), .ID_pc(ID_pc),
        .ID_funct(ID_funct),
        .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_rdata1(ID_EX_rdata1),
        .ID_EX_rdata2(ID_EX_rdata2), .ID_EX_imm(ID_EX_imm),
        .ID_EX_pc(ID_EX_pc), .ID_EX_funct(ID_EX_funct),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
        .ID_EX_rd(ID_EX_rd),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .bubble_count(bubble_count)
    );

    // Narrow counter copy so saturation is reachable quickly.
    id_ex_hazard_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CWS)) dut_s (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_rd(IF_ID_rd),
        .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_ctrl(ID_ctrl), .ID_rdata1(ID_rdata1),
        .ID_rdata2(ID_rdata2), .ID_imm(ID_imm), .ID_pc(ID_pc),
        .ID_funct(ID_funct),
        .ID_EX_ctrl(s_ctrl), .ID_EX_rdata1(s_rdata1),
        .ID_EX_rdata2(s_rdata2), .ID_EX_imm(s_imm),
        .ID_EX_pc(s_pc), .ID_EX_funct(s_funct),
        .ID_EX_rs1(s_rs1), .ID_EX_rs2(s_rs2), .ID_EX_rd(s_rd),
        .PC_Write(s_pcw), .IF_ID_Write(s_ifw),
        .bubble_count(s_bubble_count)
    );

    typedef struct packed {
        logic [8:0]    ctrl;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [3:0]    funct;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
    } st_t;

    typedef struct {
        logic       hold;
        logic       flush;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic [8:0] ctrl;
        logic       pcw;
        logic [8:0] e_ctrl;
        logic [4:0] e_rs1;
        logic [4:0] e_rd;
        int         e_cnt;
    } vec_t;

    vec_t        tbl[$];
    st_t         m;
    int unsigned nbub;
    bit          lu_s;
    int          vectors = 0;
    int          errors  = 0;

    function automatic vec_t mk(
        logic h, logic f, logic [4:0] r1, logic [4:0] r2,
        logic [4:0] rd, logic u1, logic u2, logic [8:0] c,
        logic pcw, logic [8:0] ec, logic [4:0] ers1,
        logic [4:0] erd, int ecnt);
        vec_t v;
        v.hold = h; v.flush = f; v.rs1 = r1; v.rs2 = r2;
        v.rd = rd; v.u1 = u1; v.u2 = u2; v.ctrl = c;
        v.pcw = pcw; v.e_ctrl = ec; v.e_rs1 = ers1;
        v.e_rd = erd; v.e_cnt = ecnt;
        return v;
    endfunction

    function automatic longint unsigned sat(int unsigned n, int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 1;
        return (n > mx) ? mx : longint'(n);
    endfunction

    task automatic chk(string name, logic [299:0] got,
                       logic [299:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Spec rule: a load in EX writing a non-zero rd read by ID.
    function automatic bit model_load_use();
        bit hit1, hit2;
        hit1 = IF_ID_use_rs1 && (m.rd == IF_ID_rs1);
        hit2 = IF_ID_use_rs2 && (m.rd == IF_ID_rs2);
        return m.ctrl[7] && (m.rd != 0) && (hit1 || hit2);
    endfunction

    function automatic st_t id_now();
        st_t s;
        s.ctrl = ID_ctrl; s.d1 = ID_rdata1; s.d2 = ID_rdata2;
        s.imm = ID_imm; s.pc = ID_pc; s.funct = ID_funct;
        s.rs1 = IF_ID_rs1; s.rs2 = IF_ID_rs2; s.rd = IF_ID_rd;
        return s;
    endfunction

    task automatic check_state(string tag);
        st_t g, gs;
        g.ctrl = ID_EX_ctrl; g.d1 = ID_EX_rdata1;
        g.d2 = ID_EX_rdata2; g.imm = ID_EX_imm; g.pc = ID_EX_pc;
        g.funct = ID_EX_funct; g.rs1 = ID_EX_rs1;
        g.rs2 = ID_EX_rs2; g.rd = ID_EX_rd;
        gs.ctrl = s_ctrl; gs.d1 = s_rdata1; gs.d2 = s_rdata2;
        gs.imm = s_imm; gs.pc = s_pc; gs.funct = s_funct;
        gs.rs1 = s_rs1; gs.rs2 = s_rs2; gs.rd = s_rd;
        chk({tag, ".state"}, g, m);
        chk({tag, ".state_s"}, gs, m);
        chk({tag, ".cnt"}, bubble_count, sat(nbub, CW));
        chk({tag, ".cnt_s"}, s_bubble_count, sat(nbub, CWS));
    endtask

    // Called at posedge+1; checks the combinational stall outputs.
    task automatic pre_check(string tag);
        #1;
        lu_s = model_load_use();
        chk({tag, ".pcw"}, PC_Write, !(lu_s || hold));
        chk({tag, ".ifw"}, IF_ID_Write, !(lu_s || hold));
    endtask

    // Advance one edge, update the model, check registered state.
    task automatic clock_check(string tag);
        @(posedge clk);
        if (flush) begin
            m = '0;
        end else if (!hold) begin
            if (lu_s) begin
                m = '0;
                nbub++;
            end else begin
                m = id_now();
            end
        end
        #1;
        check_state(tag);
    endtask

    task automatic set_in(logic h, logic f, logic [4:0] r1,
                          logic [4:0] r2, logic [4:0] rd,
                          logic u1, logic u2, logic [8:0] c,
                          int k);
        hold = h; flush = f;
        IF_ID_rs1 = r1; IF_ID_rs2 = r2; IF_ID_rd = rd;
        IF_ID_use_rs1 = u1; IF_ID_use_rs2 = u2;
        ID_ctrl = c;
        ID_rdata1 = 64'hA5A5_0000_0000_0000 | 64'(k);
        ID_rdata2 = 64'h5A5A_0000_0000_0000 | 64'(k * 3);
        ID_imm    = 64'hFFFF_FFFF_FFFF_F000 | 64'(k);
        ID_pc     = 64'h8000_0000 + 64'(k * 4);
        ID_funct  = 4'(k);
    endtask

    task automatic step(string tag, logic h, logic f,
                        logic [4:0] r1, logic [4:0] r2,
                        logic [4:0] rd, logic u1, logic u2,
                        logic [8:0] c, int k);
        set_in(h, f, r1, r2, rd, u1, u2, c, k);
        pre_check(tag);
        clock_check(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        m = '0;
        nbub = 0;
        lu_s = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 9'h0, 0);

        #12;
        check_state("reset");
        chk("reset.pcw", PC_Write, 1'b1);
        chk("reset.ifw", IF_ID_Write, 1'b1);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // h f rs1 rs2 rd u1 u2 ctrl | pcw ctrl rs1 rd cnt
        tbl.push_back(mk(0,0,1,2,5,1,1,C_ADD, 1,C_ADD,1,5,0));
        tbl.push_back(mk(0,0,1,2,6,1,1,C_ADD, 1,C_ADD,1,6,0));
        tbl.push_back(mk(0,0,1,2,7,1,1,C_ADD, 1,C_ADD,1,7,0));
        tbl.push_back(mk(0,0,1,0,5,1,0,C_LD,  1,C_LD,1,5,0));
        tbl.push_back(mk(0,0,5,1,6,1,1,C_ADD, 0,9'h0,0,0,1));
        tbl.push_back(mk(0,0,5,1,6,1,1,C_ADD, 1,C_ADD,5,6,1));
        tbl.push_back(mk(0,0,1,0,0,1,0,C_LD,  1,C_LD,1,0,1));
        tbl.push_back(mk(0,0,0,1,6,1,1,C_ADD, 1,C_ADD,0,6,1));
        tbl.push_back(mk(0,0,1,0,5,1,0,C_LD,  1,C_LD,1,5,1));
        tbl.push_back(mk(0,0,2,5,6,1,0,C_ADDI,1,C_ADDI,2,6,1));
        tbl.push_back(mk(0,0,1,0,5,1,0,C_LD,  1,C_LD,1,5,1));
        tbl.push_back(mk(0,1,5,1,6,1,1,C_ADD, 0,9'h0,0,0,1));
        tbl.push_back(mk(0,0,1,2,7,1,1,C_ADD, 1,C_ADD,1,7,1));
        tbl.push_back(mk(1,0,3,4,9,1,1,C_ADD, 0,C_ADD,1,7,1));
        tbl.push_back(mk(1,0,3,4,9,1,1,C_ADD, 0,C_ADD,1,7,1));
        tbl.push_back(mk(1,0,3,4,9,1,1,C_ADD, 0,C_ADD,1,7,1));
        tbl.push_back(mk(0,0,3,4,9,1,1,C_ADD, 1,C_ADD,3,9,1));
        tbl.push_back(mk(1,1,3,4,9,1,1,C_ADD, 0,9'h0,0,0,1));
        tbl.push_back(mk(0,0,1,0,5,1,0,C_LD,  1,C_LD,1,5,1));
        tbl.push_back(mk(1,0,1,5,6,1,1,C_ADD, 0,C_LD,1,5,1));
        tbl.push_back(mk(0,0,1,5,6,1,1,C_ADD, 0,9'h0,0,0,2));
        tbl.push_back(mk(0,0,1,5,6,1,1,C_ADD, 1,C_ADD,1,6,2));

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("t%0d", i);
            set_in(tbl[i].hold, tbl[i].flush, tbl[i].rs1,
                   tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
                   tbl[i].ctrl, i);
            pre_check(t);
            chk({t, ".tpcw"}, PC_Write, tbl[i].pcw);
            clock_check(t);
            chk({t, ".tctrl"}, ID_EX_ctrl, tbl[i].e_ctrl);
            chk({t, ".trs1"}, ID_EX_rs1, tbl[i].e_rs1);
            chk({t, ".trd"}, ID_EX_rd, tbl[i].e_rd);
            chk({t, ".tcnt"}, bubble_count, tbl[i].e_cnt);
        end

        // Reset asserted between edges during a load-use stall.
        step("rst.ld", 0, 0, 1, 0, 5, 1, 0, C_LD, 40);
        set_in(0, 0, 5, 2, 6, 1, 1, C_ADD, 41);
        pre_check("rst.stall");
        chk("rst.stall_pcw", PC_Write, 1'b0);
        #2 reset_n = 1'b0;
        m = '0;
        nbub = 0;
        #1;
        check_state("rst.async");
        chk("rst.async_pcw", PC_Write, 1'b1);
        chk("rst.async_ifw", IF_ID_Write, 1'b1);
        #2 reset_n = 1'b1;
        pre_check("rst.rel");
        clock_check("rst.rel");
        chk("rst.rel_ctrl", ID_EX_ctrl, C_ADD);

        // Repeated load-use bubbles drive the narrow counter to 3.
        for (int k = 0; k < 4; k++) begin
            step("sat.ld", 0, 0, 1, 0, 5, 1, 0, C_LD, 50 + k);
            step("sat.use", 0, 0, 2, 5, 6, 0, 1, C_ADD, 60 + k);
            step("sat.go", 0, 0, 2, 5, 6, 0, 1, C_ADD, 70 + k);
        end
        chk("sat.cnt_s_full", s_bubble_count, 2'b11);
        chk("sat.cnt_main", bubble_count, 16'd4);

        // Random traffic with small register indices for hazards.
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] c;
            c = 9'($urandom);
            if ($urandom_range(0, 1) == 1) c[7] = 1'b1;
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            IF_ID_rs1 = 5'($urandom_range(0, 3));
            IF_ID_rs2 = 5'($urandom_range(0, 3));
            IF_ID_rd  = ($urandom_range(0, 15) == 0)
                      ? 5'($urandom) : 5'($urandom_range(0, 3));
            IF_ID_use_rs1 = 1'($urandom);
            IF_ID_use_rs2 = 1'($urandom);
            ID_ctrl   = c;
            ID_rdata1 = {$urandom, $urandom};
            ID_rdata2 = {$urandom, $urandom};
            ID_imm    = {$urandom, $urandom};
            ID_pc     = {$urandom, $urandom};
            ID_funct  = 4'($urandom);
            pre_check("rnd");
            clock_check("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
